// File: rtl/pc_fetch_stage.sv
// pc_fetch_stage: instruction fetch stage with PC register, one-entry skid
// buffer, IF/ID pipeline register and redirect (branch/jump) handling.
// The FSM tracks whether a memory request is live (FETCH), whether an
// outstanding response must be thrown away after a redirect (DROP), and
// whether a fetched word is parked in the skid buffer behind a stall (HOLD).
module pc_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [31:0] if_instr,
  output logic        misaligned
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DROP  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic        imem_req_r;
  logic        req_next_s;

  logic [31:0] pc_r;
  logic [31:0] pc_next_s;
  logic [31:0] pc_plus4_s;
  logic        misaligned_r;

  logic        redirect_s;
  logic [31:0] raw_target_s;
  logic [31:0] target_s;
  logic        target_misaligned_s;

  logic        if_valid_r;
  logic [31:0] if_pc_r;
  logic [31:0] if_pc_plus4_r;
  logic [31:0] if_instr_r;

  logic        skid_valid_r;
  logic [31:0] skid_pc_r;
  logic [31:0] skid_instr_r;

  logic        ifid_load_s;
  logic        ifid_clear_s;
  logic        ifid_from_skid_s;
  logic        ifid_valid_in_s;
  logic [31:0] ifid_pc_in_s;
  logic [31:0] ifid_instr_in_s;
  logic        skid_load_s;
  logic        skid_clear_s;

  assign redirect_s = branch_taken | jump;
  assign pc_plus4_s = pc_r + 32'd4;

  // Redirect target selection: branch wins over jump, low bits are forced to zero
  always_comb begin
    if (branch_taken) begin
      raw_target_s = branch_target;
    end else begin
      raw_target_s = jump_target;
    end
    target_s            = {raw_target_s[31:2], 2'b00};
    target_misaligned_s = |raw_target_s[1:0];
  end

  // State register together with the fetch request it implies
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      imem_req_r <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      imem_req_r <= req_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        state_next_s = ST_FETCH;
      end
      ST_FETCH: begin
        if (redirect_s) begin
          // A still-pending response belongs to the old stream and must be dropped
          if (imem_ready) begin
            state_next_s = ST_FETCH;
          end else begin
            state_next_s = ST_DROP;
          end
        end else if (imem_ready && stall) begin
          state_next_s = ST_HOLD;
        end else begin
          state_next_s = ST_FETCH;
        end
      end
      ST_DROP: begin
        if (imem_ready) begin
          state_next_s = ST_FETCH;
        end else begin
          state_next_s = ST_DROP;
        end
      end
      ST_HOLD: begin
        if (redirect_s || !stall) begin
          state_next_s = ST_FETCH;
        end else begin
          state_next_s = ST_HOLD;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Output and datapath control decoded from state and inputs
  always_comb begin
    req_next_s       = (state_next_s == ST_FETCH) || (state_next_s == ST_DROP);
    pc_next_s        = pc_r;
    ifid_load_s      = 1'b0;
    ifid_clear_s     = 1'b0;
    ifid_from_skid_s = 1'b0;
    skid_load_s      = 1'b0;
    skid_clear_s     = 1'b0;
    if (redirect_s) begin
      // Flush applies even under stall: the held instruction is on the wrong path
      pc_next_s    = target_s;
      ifid_clear_s = 1'b1;
      skid_clear_s = 1'b1;
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (imem_ready) begin
            pc_next_s = pc_plus4_s;
            if (stall) begin
              skid_load_s = 1'b1;
            end else begin
              ifid_load_s = 1'b1;
            end
          end else if (!stall) begin
            // Decode consumed the current entry and nothing new arrived
            ifid_clear_s = 1'b1;
          end else begin
            ifid_clear_s = 1'b0;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            ifid_load_s      = 1'b1;
            ifid_from_skid_s = 1'b1;
            skid_clear_s     = 1'b1;
          end else begin
            ifid_load_s = 1'b0;
          end
        end
        ST_DROP: begin
          if (!stall) begin
            ifid_clear_s = 1'b1;
          end else begin
            ifid_clear_s = 1'b0;
          end
        end
        ST_IDLE: begin
          ifid_clear_s = 1'b0;
        end
        default: begin
          ifid_clear_s = 1'b1;
        end
      endcase
    end
  end

  // Source mux feeding the IF/ID register: fresh memory word or skid entry
  always_comb begin
    if (ifid_from_skid_s) begin
      ifid_valid_in_s = skid_valid_r;
      ifid_pc_in_s    = skid_pc_r;
      ifid_instr_in_s = skid_instr_r;
    end else begin
      ifid_valid_in_s = 1'b1;
      ifid_pc_in_s    = pc_r;
      ifid_instr_in_s = imem_rdata;
    end
  end

  // PC register and sticky misaligned-target flag
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r         <= RESET_PC;
      misaligned_r <= 1'b0;
    end else begin
      pc_r <= pc_next_s;
      if (redirect_s && target_misaligned_s) begin
        misaligned_r <= 1'b1;
      end
    end
  end

  // IF/ID pipeline register; pc+4 is registered alongside the pc
  always_ff @(posedge clk) begin
    if (reset) begin
      if_valid_r    <= 1'b0;
      if_pc_r       <= 32'h0000_0000;
      if_pc_plus4_r <= 32'h0000_0000;
      if_instr_r    <= 32'h0000_0000;
    end else if (ifid_clear_s) begin
      if_valid_r <= 1'b0;
    end else if (ifid_load_s) begin
      if_valid_r    <= ifid_valid_in_s;
      if_pc_r       <= ifid_pc_in_s;
      if_pc_plus4_r <= ifid_pc_in_s + 32'd4;
      if_instr_r    <= ifid_instr_in_s;
    end
  end

  // One-entry skid buffer catching a word that arrives while decode stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      skid_valid_r <= 1'b0;
      skid_pc_r    <= 32'h0000_0000;
      skid_instr_r <= 32'h0000_0000;
    end else if (skid_clear_s) begin
      skid_valid_r <= 1'b0;
    end else if (skid_load_s) begin
      skid_valid_r <= 1'b1;
      skid_pc_r    <= pc_r;
      skid_instr_r <= imem_rdata;
    end
  end

  assign imem_req    = imem_req_r;
  assign imem_addr   = pc_r;
  assign if_valid    = if_valid_r;
  assign if_pc       = if_pc_r;
  assign if_pc_plus4 = if_pc_plus4_r;
  assign if_instr    = if_instr_r;
  assign misaligned  = misaligned_r;

endmodule

// File: doc/pc_fetch_stage.md
PC_FETCH_STAGE -- requirements
Module: pc_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset; bits [1:0] SHALL be 0.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 stall  input  1  decode stage cannot accept; IF/ID outputs hold.
REQ-005 branch_taken  input  1  redirect to branch_target this cycle.
REQ-006 branch_target  input  32  branch destination address.
REQ-007 jump  input  1  redirect to jump_target this cycle.
REQ-008 jump_target  input  32  jump destination address.
REQ-009 imem_req  output  1  fetch request to instruction memory.
REQ-010 imem_addr  output  32  fetch address; always equals the PC register.
REQ-011 imem_ready  input  1  memory response valid this cycle; meaningful only while imem_req=1.
REQ-012 imem_rdata  input  32  instruction word, valid when imem_ready=1.
REQ-013 if_valid  output  1  IF/ID register holds a live instruction.
REQ-014 if_pc  output  32  address of the instruction in IF/ID.
REQ-015 if_pc_plus4  output  32  if_pc + 4, modulo 2^32.
REQ-016 if_instr  output  32  instruction word in IF/ID.
REQ-017 misaligned  output  1  sticky flag: a redirect target had bits [1:0] != 0.

Function
REQ-018 FSM states SHALL be IDLE, FETCH, DROP and HOLD; imem_req=1 only in FETCH and DROP.
REQ-019 IDLE lasts exactly one cycle after reset and SHALL then go to FETCH.
REQ-020 Sequential PC SHALL be pc + 4 using 32-bit unsigned addition; 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
REQ-021 Redirect is branch_taken OR jump; when both are high, branch_target SHALL win.
REQ-022 Redirect target bits [1:0] SHALL be forced to 0; if they were nonzero, misaligned SHALL be set and held until reset.
REQ-023 FETCH with imem_ready=1, stall=0, no redirect: capture if_instr=imem_rdata, if_pc=pc, if_valid=1, pc<=pc+4, stay in FETCH.
REQ-024 FETCH with imem_ready=1, stall=1, no redirect: store the word and its PC in a one-entry skid buffer, pc<=pc+4, go to HOLD; IF/ID outputs unchanged.
REQ-025 HOLD: imem_req=0; when stall falls, move the skid entry into IF/ID with if_valid=1, then go to FETCH.
REQ-026 FETCH with imem_ready=0 and stall=1: IF/ID outputs unchanged, request stays outstanding.
REQ-027 Redirect in any state: pc<=target; if_valid<=0 and skid buffer cleared the next cycle, even with stall=1.
REQ-028 Redirect in FETCH with imem_ready=0: go to DROP; the outstanding response SHALL be discarded.
REQ-029 DROP: imem_addr already shows the new target; on imem_ready=1 discard data and go to FETCH, pc unchanged.
REQ-030 Redirect in the same cycle as imem_ready=1: discard the data and go to FETCH with pc=target.
REQ-031 Redirect in HOLD: discard the skid entry and go to FETCH.
REQ-032 Minimum latency is one cycle from imem_ready=1 to the word appearing on if_instr.
REQ-033 Sustained throughput SHALL be one instruction per cycle while imem_ready=1 and stall=0.
REQ-034 if_pc_plus4 SHALL be registered together with if_pc.

Reset
REQ-035 Reset SHALL have priority over all inputs and take effect at the next rising edge, including mid-fetch and in DROP/HOLD.
REQ-036 Reset values: pc=RESET_PC, state=IDLE, imem_req=0, if_valid=0, if_pc=0, if_pc_plus4=0, if_instr=0, misaligned=0, skid buffer empty.
REQ-037 A memory response arriving in the cycle after reset SHALL be ignored, because imem_req=0 in IDLE.

Verification
REQ-038 Reset, imem_ready tied 1, stall=0 -> imem_addr sequence 0,4,8,C; if_pc lags imem_addr by one cycle; if_valid=1 from cycle 3.
REQ-039 stall=1 for 3 cycles while fetching addr 0x10 -> IF/ID holds 0x0C; HOLD entered; after stall falls, if_pc=0x10 then 0x14, with no instruction lost or duplicated.
REQ-040 imem_ready=0, jump=1 to 0x200 in the same cycle, response arrives 2 cycles later -> response dropped; next accepted if_pc=0x200.
REQ-041 branch_taken and jump both high, branch_target=0x80, jump_target=0x40 -> pc=0x80; if_valid=0 the next cycle.
REQ-042 Redirect to 0x103 -> pc=0x100, misaligned=1 and held; reset clears it.
REQ-043 RESET_PC=32'hFFFF_FFF8, imem_ready=1 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; if_pc_plus4 for FFFF_FFFC reads 0000_0000.
